// File: rtl/ps2_mouse_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_mouse_rx : PS/2 mouse receiver, 3-byte packets to a 25-bit toggle bus   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ps2_mouse_rx #(
  parameter int FILTER_LEN = 8,
  parameter int BIT_TMO    = 12000,
  parameter int PKT_TMO    = 30000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_6mp,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [24:0] ps2_mouse,
  output logic        frame_err,
  output logic        busy
);

  localparam int              FW         = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0]   C_FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [15:0]     C_BIT_TMO  = 16'(BIT_TMO);
  localparam logic [15:0]     C_PKT_TMO  = 16'(PKT_TMO);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_clk_q, filt_clk_d;
  logic          filt_prev_q, filt_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [15:0]   bit_tmo_q, bit_tmo_d;
  logic [15:0]   pkt_tmo_q, pkt_tmo_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    dx_q, dx_d;
  logic [24:0]   mouse_q, mouse_d;
  logic          err_q, err_d;

  logic          fall;
  logic          dat_s;
  logic          frame_ok;

  // Input conditioning: synchronizers and the clock-line glitch filter.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    dat_sync_d  = {dat_sync_q[0], ps2_data};
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = filt_cnt_q;
    filt_prev_d = filt_clk_q;
    if (clk_sync_q[1] == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == C_FILT_MAX) begin
      filt_clk_d = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  assign fall     = filt_prev_q & ~filt_clk_q;
  assign dat_s    = dat_sync_q[1];
  assign frame_ok = (^{shift_q, par_q}) & dat_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_tmo_d = bit_tmo_q;
    pkt_tmo_d = pkt_tmo_q;
    idx_d     = idx_q;
    status_d  = status_q;
    dx_d      = dx_q;
    mouse_d   = mouse_q;
    err_d     = 1'b0;

    // Saturating timeout counters; an edge always clears them.
    if (state_q == S_IDLE || fall) begin
      bit_tmo_d = '0;
    end else if (ce_6mp && bit_tmo_q != C_BIT_TMO) begin
      bit_tmo_d = bit_tmo_q + 16'd1;
    end

    if (idx_q == 2'd0 || state_q != S_IDLE || fall) begin
      pkt_tmo_d = '0;
    end else if (ce_6mp && pkt_tmo_q != C_PKT_TMO) begin
      pkt_tmo_d = pkt_tmo_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (fall && !dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end else if (!fall && idx_q != 2'd0 && pkt_tmo_q == C_PKT_TMO) begin
          idx_d = 2'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (!frame_ok) begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end else begin
            case (idx_q)
              2'd0: begin
                // Byte 0 of a movement packet always has bit 3 set; use it to resync.
                if (shift_q[3]) begin
                  status_d = shift_q;
                  idx_d    = 2'd1;
                end else begin
                  err_d = 1'b1;
                end
              end
              2'd1: begin
                dx_d  = shift_q;
                idx_d = 2'd2;
              end
              default: begin
                mouse_d = {~mouse_q[24], shift_q, dx_q, status_q};
                idx_d   = 2'd0;
              end
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled frame is abandoned quietly.
    if (state_q != S_IDLE && !fall && bit_tmo_q == C_BIT_TMO) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_tmo_q   <= '0;
      pkt_tmo_q   <= '0;
      idx_q       <= '0;
      status_q    <= '0;
      dx_q        <= '0;
      mouse_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_prev_q <= filt_prev_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_tmo_q   <= bit_tmo_d;
      pkt_tmo_q   <= pkt_tmo_d;
      idx_q       <= idx_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      mouse_q     <= mouse_d;
      err_q       <= err_d;
    end
  end

  assign ps2_mouse = mouse_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_rx.sv
`default_nettype none
// Bench for ps2_mouse_rx: byte-level packet model with per-cycle output compare.
module tb_ps2_mouse_rx;
  localparam int FILTER_LEN = 8;
  localparam int BIT_TMO    = 400;
  localparam int PKT_TMO    = 1500;
  localparam int HALF       = 22;
  localparam int GAP        = 10;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ce_6mp  = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;
  logic        busy;

  ps2_mouse_rx #(
    .FILTER_LEN(FILTER_LEN),
    .BIT_TMO   (BIT_TMO),
    .PKT_TMO   (PKT_TMO)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_6mp   (ce_6mp),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_mouse(ps2_mouse),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int ce_ticks = 0;
  bit done = 0;

  // Packet-level model
  logic [24:0] exp_q[$];
  logic [24:0] cur_exp = '0;
  logic [24:0] m_last  = '0;
  int          err_pend = 0;
  int          m_idx = 0;
  logic [7:0]  m_st = '0;
  logic [7:0]  m_dx = '0;
  logic        m_tog = 1'b0;

  function automatic void model_reset();
    exp_q.delete();
    cur_exp  = '0;
    m_last   = '0;
    err_pend = 0;
    m_idx    = 0;
    m_tog    = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      err_pend++;
      m_idx = 0;
    end else if (m_idx == 0) begin
      if (b[3]) begin
        m_st  = b;
        m_idx = 1;
      end else begin
        err_pend++;
      end
    end else if (m_idx == 1) begin
      m_dx  = b;
      m_idx = 2;
    end else begin
      m_tog  = ~m_tog;
      m_last = {m_tog, b, m_dx, m_st};
      exp_q.push_back(m_last);
      m_idx  = 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic lit_chk(input string nm, input logic [24:0] lit);
    chk({nm, "_dut"}, {7'd0, ps2_mouse}, {7'd0, lit});
    chk({nm, "_model"}, {7'd0, m_last}, {7'd0, lit});
  endtask

  // ce_6mp: random ~50% duty, ticks counted for timeout stalls
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      ce_6mp = ($urandom_range(0, 1) == 1);
      if (ce_6mp) ce_ticks++;
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset === 1'b0 && !done) begin
        checks++;
        if (ps2_mouse !== cur_exp) begin
          if (exp_q.size() > 0 && ps2_mouse === exp_q[0]) begin
            cur_exp = exp_q.pop_front();
          end else begin
            errors++;
            $display("FAIL ps2_mouse got=%h exp=%h", ps2_mouse, (exp_q.size() > 0) ? exp_q[0] : cur_exp);
            cur_exp = ps2_mouse;
          end
        end
        checks++;
        if (frame_err !== 1'b0) begin
          if (frame_err === 1'b1 && err_pend > 0) begin
            err_pend--;
          end else begin
            errors++;
            $display("FAIL frame_err got=%b pending=%0d", frame_err, err_pend);
          end
        end
      end
    end
  end

  task automatic ps2_bit(input logic d, input bit glitch);
    ps2_data = d;
    repeat (6) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
    if (glitch) begin
      repeat (8) @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 2) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    repeat (HALF - 6) @(negedge clk_sys);
  endtask

  // mode: 0 good, 1 bad parity, 2 bad stop; gbit = bit index followed by a clock glitch
  task automatic send_byte(input logic [7:0] b, input int mode, input int gbit);
    logic [10:0] fr;
    model_byte(b, mode == 0);
    fr = {(mode == 2) ? 1'b0 : 1'b1, (mode == 1) ? (^b) : ~(^b), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(fr[i], i == gbit);
      if (i == 4) chk("busy_mid", {31'd0, busy}, 32'd1);
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk_sys);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    int guard;
    t0 = ce_ticks;
    guard = 0;
    while ((ce_ticks - t0) < n && guard < 10 * n + 100) begin
      @(negedge clk_sys);
      guard++;
    end
    chk("tick_wait_bound", {31'd0, ((ce_ticks - t0) >= n)}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk_sys);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mouse", {7'd0, ps2_mouse}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk_sys);
    #2;
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    send_byte(s, 0, -1);
    send_byte(x, 0, -1);
    send_byte(y, 0, -1);
  endtask

  initial begin
    logic [7:0] b;
    int mode;
    int r;
    model_reset();
    do_reset();

    // Valid packet twice: toggle flips each time
    send_pkt(8'h09, 8'h05, 8'hFB);
    lit_chk("pkt1", 25'h1FB0509);
    send_pkt(8'h09, 8'h05, 8'hFB);
    lit_chk("pkt2", 25'h0FB0509);

    // Bad parity on second byte resynchronises
    do_reset();
    send_byte(8'h08, 0, -1);
    send_byte(8'h10, 1, -1);
    chk("no_partial_update", {7'd0, ps2_mouse}, 32'd0);
    send_pkt(8'h08, 8'h02, 8'h03);
    lit_chk("parity", 25'h1030208);

    // Status byte without bit 3 is rejected
    do_reset();
    send_byte(8'h01, 0, -1);
    send_pkt(8'h18, 8'h7F, 8'h80);
    lit_chk("bit3", 25'h1807F18);

    // Bit timeout mid-frame
    do_reset();
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("busy_stall", {31'd0, busy}, 32'd1);
    wait_ticks(BIT_TMO + 10);
    m_idx = 0;
    chk("busy_tmo", {31'd0, busy}, 32'd0);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk_sys);
    send_pkt(8'h0A, 8'h01, 8'h02);
    lit_chk("bit_tmo", 25'h102010A);

    // Clock glitches shorter than the filter
    do_reset();
    send_byte(8'h29, 0, 2);
    send_byte(8'h44, 0, -1);
    send_byte(8'h99, 0, 6);
    lit_chk("glitch", 25'h1994429);

    // Reset during the second byte's data bits
    send_byte(8'h09, 0, -1);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    chk("busy_pre_rst", {31'd0, busy}, 32'd1);
    do_reset();
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk_sys);
    send_pkt(8'h09, 8'h00, 8'h00);
    lit_chk("after_rst", 25'h1000009);

    // Inter-byte timeout drops a partial packet
    send_byte(8'h08, 0, -1);
    wait_ticks(PKT_TMO + 20);
    m_idx = 0;
    send_pkt(8'h0C, 8'h11, 8'h22);
    lit_chk("pkt_tmo", 25'h022110C);

    // Randomised byte stream with occasional framing errors
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        r = $urandom_range(0, 99);
        mode = (r < 8) ? 1 : ((r < 14) ? 2 : 0);
        if (k == 0 && $urandom_range(0, 4) != 0) b[3] = 1'b1;
        send_byte(b, mode, -1);
        repeat ($urandom_range(0, 40)) @(negedge clk_sys);
      end
    end

    repeat (40) @(negedge clk_sys);
    chk("pending_pkts", 32'(exp_q.size()), 32'd0);
    chk("pending_errs", 32'(err_pend), 32'd0);
    chk("final_mouse", {7'd0, ps2_mouse}, {7'd0, m_last});
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
- Receives the raw PS/2 mouse serial stream (device-to-host clock/data lines).
- Assembles standard 3-byte movement packets and presents them as the 25-bit `ps2_mouse` bus consumed by the SAM mouse interface.
- Bit 24 of `ps2_mouse` is a toggle strobe: it flips once per complete, valid packet.
- Sits between the PS/2 pins (or the host-supplied PS/2 lines) and the SAM mouse block.

Parameters:
- FILTER_LEN, 8: consecutive identical clk_sys samples required before filtered ps2_clk changes state.
- BIT_TMO, 12000: ce_6mp ticks (~2 ms) without a ps2_clk falling edge inside a frame before the frame is aborted.
- PKT_TMO, 30000: ce_6mp ticks (~5 ms) between bytes of one packet before the packet index returns to byte 0.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_6mp  in  1  6 MHz clock enable, used for timeouts only
- ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- ps2_data  in  1  raw PS/2 data line (asynchronous)
- ps2_mouse  out  25  {toggle, dy[7:0], dx[7:0], status[7:0]}
- frame_err  out  1  one-cycle pulse on any discarded byte or packet
- busy  out  1  high while a frame is being received

Behaviour:
- Input conditioning
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clk changes only after FILTER_LEN equal synchronized samples; its reset value is 1.
  - A falling edge of filtered clk samples synchronized data. These are the only sample points.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a falling edge with data=0, go to DATA, bit_cnt=0, busy=1. Data=1 is ignored.
  - DATA: shift data into the byte LSB-first; after 8 bits go to PARITY.
  - PARITY: capture the bit; odd parity over data+parity is required. Go to STOP.
  - STOP: data must be 1. Frame OK means parity good and stop=1. Any failure: drop the byte, pulse frame_err, set packet index to 0. Always return to IDLE, busy=0.
- Bit timeout
  - In any non-IDLE state, the tick counter increments on ce_6mp and clears on each falling edge.
  - At BIT_TMO: abort to IDLE, packet index=0, no frame_err.
- Packet assembly, index 0..2
  - idx0: accept the byte only if bit3=1. Otherwise drop it, pulse frame_err, stay at idx0.
  - idx1 stores dx; idx2 stores dy.
  - After a valid idx2 byte: `ps2_mouse <= {~ps2_mouse[24], dy, dx, status}` one clk_sys cycle after the stop-bit edge is processed. Index returns to 0.
- Packet timeout
  - While idx≠0 and the FSM is in IDLE, an inter-byte counter runs on ce_6mp.
  - At PKT_TMO: idx=0, and partial bytes are discarded silently.
- ps2_mouse holds its last value between packets. status/dx/dy are never partially updated.
- Timeout counters are 16 bits and saturate at the threshold; they never wrap.
- Simultaneous events:
  - A falling edge and a timeout in the same cycle: the edge wins and the counter clears.
  - A ce_6mp tick with an edge: the edge wins.
- Reset, asserted any time (including mid-frame), asynchronous:
  - ps2_mouse=0, frame_err=0, busy=0, FSM=IDLE, idx=0, all counters=0, filtered clk=1.
- Reset values: every output is 0.

Test Plan:
- Three valid frames 0x09, 0x05, 0xFB from reset → ps2_mouse=25'h1FB0509 one cycle after the third stop edge; frame_err never pulses. A second identical packet → 25'h0FB0509.
- Bytes 0x08, then 0x10 with bad parity, then 0x08, 0x02, 0x03 → one frame_err pulse on the 2nd byte, no update from the first attempt; final ps2_mouse=25'h1030208.
- Byte 0x01 (bit3=0), then 0x18, 0x7F, 0x80 → frame_err pulse on the first byte; ps2_mouse=25'h1807F18.
- Stall of BIT_TMO+10 ce_6mp ticks after 5 data bits, then a full packet 0x0A, 0x01, 0x02 → busy drops at the timeout with no frame_err; ps2_mouse=25'h102010A.
- Two ps2_clk low glitches of FILTER_LEN-2 cycles inside a valid packet → ignored; the packet decodes exactly.
- Assert reset during the DATA state of byte 2 → outputs 0 immediately; the next full packet 0x09, 0x00, 0x00 gives 25'h1000009.
